// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART-controlled ALU: frame defaults, opcodes and
// the encoding of the operand-collecting interface FSM.
package uart_alu_pkg;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int DVSR_DEF    = 326;
  localparam int NB_OP_DEF   = 8;

  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_SRL = 8'h02;

  localparam logic [1:0] IF_WAIT_A  = 2'd0;
  localparam logic [1:0] IF_WAIT_B  = 2'd1;
  localparam logic [1:0] IF_WAIT_OP = 2'd2;
  localparam logic [1:0] IF_SEND    = 2'd3;

endpackage

// File: rtl/uart_alu_bridge_alu.sv
// Combinational ALU; results wrap, unknown opcodes yield zero.
module alu
  import uart_alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OP_W   = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y
);

  logic signed [DATA_W-1:0] a_s;

  assign a_s = signed'(a);

  // Shifts by DATA_W or more saturate to sign fill (SRA) or zero (SRL).
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_SRA:  y = a_s >>> b;
      OP_SRL:  y = a >> b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/uart_alu_bridge.sv
// UART front end for the ALU: collects A, B, opcode as three 8N1 bytes and
// transmits the single result byte back.
module uart_alu_bridge
  import uart_alu_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int DVSR    = DVSR_DEF,
  parameter int NB_OP   = NB_OP_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_rx,
  output logic o_tx
);

  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SW = $clog2((SB_TICK > 16) ? SB_TICK : 16);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [CW-1:0]    tick_cnt;
  logic             s_tick;
  logic             rx_p0, rx_p1;
  logic [1:0]       rx_state, tx_state, if_state;
  logic [SW-1:0]    rx_s, tx_s;
  logic [NW-1:0]    rx_n, tx_n;
  logic [DBIT-1:0]  rx_b, tx_b;
  logic             rx_done, tx_done, tx_start, tx_reg;
  logic [DBIT-1:0]  a_reg, b_reg, alu_y;
  logic [NB_OP-1:0] op_reg;

  assign s_tick = (tick_cnt == CW'(DVSR - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) tick_cnt <= '0;
    else if (s_tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  // Input stage: two-flop synchroniser, idles high so reset cannot fake a start.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= i_rx;
      rx_p1 <= rx_p0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_state <= S_IDLE;
      rx_s     <= '0;
      rx_n     <= '0;
      rx_b     <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (rx_state)
        S_IDLE: if (!rx_p1) begin
          rx_state <= S_START;
          rx_s     <= '0;
        end
        S_START: if (s_tick) begin
          if (rx_s == SW'(7)) begin
            rx_s     <= '0;
            rx_n     <= '0;
            rx_state <= rx_p1 ? S_IDLE : S_DATA;
          end else rx_s <= rx_s + 1'b1;
        end
        S_DATA: if (s_tick) begin
          if (rx_s == SW'(15)) begin
            rx_s <= '0;
            rx_b <= {rx_p1, rx_b[DBIT-1:1]};
            if (rx_n == NW'(DBIT - 1)) rx_state <= S_STOP;
            else rx_n <= rx_n + 1'b1;
          end else rx_s <= rx_s + 1'b1;
        end
        default: if (s_tick) begin
          if (rx_s == SW'(SB_TICK - 1)) begin
            rx_state <= S_IDLE;
            rx_done  <= rx_p1;
          end else rx_s <= rx_s + 1'b1;
        end
      endcase
    end
  end

  // Operand collection; SEND also accepts a byte so none is lost on the way back to WAIT_A.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      if_state <= IF_WAIT_A;
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= '0;
    end else begin
      case (if_state)
        IF_WAIT_A: if (rx_done) begin
          a_reg    <= rx_b;
          if_state <= IF_WAIT_B;
        end
        IF_WAIT_B: if (rx_done) begin
          b_reg    <= rx_b;
          if_state <= IF_WAIT_OP;
        end
        IF_WAIT_OP: if (rx_done) begin
          op_reg   <= rx_b[NB_OP-1:0];
          if_state <= IF_SEND;
        end
        default: begin
          if (rx_done) begin
            a_reg    <= rx_b;
            if_state <= IF_WAIT_B;
          end else if_state <= IF_WAIT_A;
        end
      endcase
    end
  end

  assign tx_start = (if_state == IF_SEND);

  alu #(.DATA_W(DBIT), .OP_W(NB_OP)) u_alu (
    .a  (a_reg),
    .b  (b_reg),
    .op (op_reg),
    .y  (alu_y)
  );

  assign tx_done = (tx_state == S_STOP) && s_tick && (tx_s == SW'(SB_TICK - 1));

  // Output stage: registered line driver; a start while busy is dropped.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tx_state <= S_IDLE;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_b     <= '0;
      tx_reg   <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: if (tx_start) begin
          tx_state <= S_START;
          tx_s     <= '0;
          tx_b     <= alu_y;
          tx_reg   <= 1'b0;
        end
        S_START: if (s_tick) begin
          if (tx_s == SW'(15)) begin
            tx_state <= S_DATA;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_reg   <= tx_b[0];
          end else tx_s <= tx_s + 1'b1;
        end
        S_DATA: if (s_tick) begin
          if (tx_s == SW'(15)) begin
            tx_s <= '0;
            tx_b <= tx_b >> 1;
            if (tx_n == NW'(DBIT - 1)) begin
              tx_state <= S_STOP;
              tx_reg   <= 1'b1;
            end else begin
              tx_n   <= tx_n + 1'b1;
              tx_reg <= tx_b[1];
            end
          end else tx_s <= tx_s + 1'b1;
        end
        default: begin
          if (tx_done) begin
            tx_state <= S_IDLE;
            tx_s     <= '0;
          end else if (s_tick) tx_s <= tx_s + 1'b1;
        end
      endcase
    end
  end

  assign o_tx = tx_reg;

endmodule

// File: tb/tb_uart_alu_bridge.sv
// Bench for uart_alu_bridge with a shortened baud divider; a line monitor
// decodes o_tx frames and results are checked against a behavioural ALU model.
module tb_uart_alu_bridge;

  localparam int CLK_NS  = 20;
  localparam int DVSR_TB = 2;
  localparam int BIT_NS  = 16 * DVSR_TB * CLK_NS;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_rx = 1'b1;
  logic o_tx;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     rxq[$];
  longint lat_q[$];
  longint done_t = 0;
  int     mon_v;

  uart_alu_bridge #(.DBIT(8), .SB_TICK(16), .DVSR(DVSR_TB), .NB_OP(8)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_rx    (i_rx),
    .o_tx    (o_tx)
  );

  always #(CLK_NS / 2) i_clk = ~i_clk;

  always @(negedge i_clk) if (dut.rx_done === 1'b1) done_t = longint'($time);

  // Line monitor: decode each o_tx frame at mid-bit; bit 8 flags a bad stop, bit 9 a bad start.
  initial begin
    forever begin
      @(negedge o_tx);
      lat_q.push_back(longint'($time) - done_t);
      #(BIT_NS / 2);
      mon_v = (o_tx !== 1'b0) ? 'h200 : 0;
      for (int i = 0; i < 8; i++) begin
        #(BIT_NS);
        if (o_tx === 1'b1) mon_v |= (1 << i);
      end
      #(BIT_NS);
      if (o_tx !== 1'b1) mon_v |= 'h100;
      rxq.push_back(mon_v);
    end
  end

  initial begin
    #(3ms);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int ref_alu(int a, int b, int op);
    int sa;
    case (op)
      'h20: return (a + b) % 256;
      'h22: return (a - b + 256) % 256;
      'h24: return a & b;
      'h25: return a | b;
      'h26: return a ^ b;
      'h27: return 255 - (a | b);
      'h03: begin
        sa = (a >= 128) ? a - 256 : a;
        return (sa >>> ((b > 31) ? 31 : b)) & 255;
      end
      'h02: return (b >= 8) ? 0 : a / (1 << b);
      default: return 0;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    i_rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      #(BIT_NS);
    end
    if (good_stop) begin
      i_rx = 1'b1;
      #(BIT_NS);
    end else begin
      i_rx = 1'b0;
      #(BIT_NS * 3 / 4);
      i_rx = 1'b1;
      #(BIT_NS);
    end
  endtask

  task automatic send_triplet(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(op, 1'b1);
  endtask

  task automatic wait_frame(output int v, output bit ok);
    ok = 1'b0;
    v  = -1;
    for (int i = 0; i < 1500; i++) begin
      if (rxq.size() != 0) break;
      @(posedge i_clk);
    end
    if (rxq.size() != 0) begin
      v  = rxq.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int lows;
    lows = 0;
    i_rx = 1'b1;
    #1 i_reset = 1'b0;
    #5;
    n_cmp++;
    if (o_tx !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_tx: o_tx=%b expected 1", o_tx);
    end
    #5 i_reset = 1'b1;
    repeat (1000) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1) lows++;
    end
    n_cmp++;
    if (lows != 0) begin
      n_bad++;
      $display("FAIL idle_tx: %0d low samples, expected 0", lows);
    end
    n_cmp++;
    if (rxq.size() != 0) begin
      n_bad++;
      $display("FAIL idle_frames: %0d frames, expected 0", rxq.size());
    end
  endtask

  task automatic test_add();
    int v;
    bit ok;
    longint lat;
    lat_q.delete();
    send_triplet(8'h40, 8'h40, 8'h20);
    wait_frame(v, ok);
    n_cmp++;
    if (!ok || v != 'h80) begin
      n_bad++;
      $display("FAIL add_result: got %0h (seen %0d) expected 80", v, ok);
    end
    lat = (lat_q.size() != 0) ? lat_q[0] : -1;
    n_cmp++;
    if (lat <= 0 || lat > 2 * CLK_NS) begin
      n_bad++;
      $display("FAIL add_latency: %0d ns after opcode byte, expected 1..%0d ns", lat, 2 * CLK_NS);
    end
  endtask

  task automatic test_invalid_op();
    int v;
    bit ok;
    send_triplet(8'h40, 8'h40, 8'h04);
    wait_frame(v, ok);
    n_cmp++;
    if (!ok || v != 'h00) begin
      n_bad++;
      $display("FAIL invalid_op: got %0h (seen %0d) expected 00", v, ok);
    end
  endtask

  task automatic test_ops();
    logic [7:0] ta [5];
    logic [7:0] tb [5];
    logic [7:0] to [5];
    int         te [5];
    int v;
    bit ok;
    ta = '{8'h05, 8'h80, 8'h80, 8'h0F, 8'hAA};
    tb = '{8'h07, 8'h03, 8'h03, 8'hF0, 8'hFF};
    to = '{8'h22, 8'h03, 8'h02, 8'h27, 8'h26};
    te = '{'hFE, 'hF0, 'h10, 'h00, 'h55};
    for (int k = 0; k < 5; k++) begin
      send_triplet(ta[k], tb[k], to[k]);
      wait_frame(v, ok);
      n_cmp++;
      if (!ok || v != te[k]) begin
        n_bad++;
        $display("FAIL op_%02h: A=%02h B=%02h got %0h (seen %0d) expected %02h",
                 to[k], ta[k], tb[k], v, ok, te[k]);
      end
    end
  endtask

  task automatic test_glitch();
    int v;
    bit ok;
    i_rx = 1'b0;
    #(BIT_NS / 4);
    i_rx = 1'b1;
    #(2 * BIT_NS);
    send_triplet(8'h12, 8'h34, 8'h20);
    wait_frame(v, ok);
    n_cmp++;
    if (!ok || v != 'h46) begin
      n_bad++;
      $display("FAIL glitch: got %0h (seen %0d) expected 46", v, ok);
    end
  endtask

  task automatic test_framing();
    int v;
    bit ok;
    send_byte(8'h5A, 1'b0);
    #(2 * BIT_NS);
    send_triplet(8'h10, 8'h03, 8'h22);
    wait_frame(v, ok);
    n_cmp++;
    if (!ok || v != 'h0D) begin
      n_bad++;
      $display("FAIL framing: got %0h (seen %0d) expected 0d", v, ok);
    end
  endtask

  task automatic test_reset_mid_op();
    int v;
    bit ok;
    send_byte(8'h07, 1'b1);
    send_byte(8'h09, 1'b1);
    i_rx = 1'b0;
    #(5 * BIT_NS + BIT_NS / 2);
    i_reset = 1'b0;
    #(BIT_NS / 2);
    n_cmp++;
    if (o_tx !== 1'b1) begin
      n_bad++;
      $display("FAIL midop_reset_tx: o_tx=%b expected 1", o_tx);
    end
    i_rx = 1'b1;
    i_reset = 1'b1;
    #(2 * BIT_NS);
    send_triplet(8'h01, 8'h02, 8'h20);
    wait_frame(v, ok);
    n_cmp++;
    if (!ok || v != 'h03) begin
      n_bad++;
      $display("FAIL midop_result: got %0h (seen %0d) expected 03", v, ok);
    end
    #(12 * BIT_NS);
    n_cmp++;
    if (rxq.size() != 0) begin
      n_bad++;
      $display("FAIL midop_spurious: %0d extra frames, expected 0", rxq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [8];
    logic [7:0] ra, rb, rop;
    int exp_q[$];
    int v, e;
    bit ok;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        ra = 8'h81; rb = 8'd9; rop = 8'h03;
      end else if (k == 1) begin
        ra = 8'hFF; rb = 8'd8; rop = 8'h02;
      end else begin
        ra  = 8'($urandom);
        rop = ($urandom_range(0, 4) == 0) ? 8'($urandom) : ops[$urandom_range(0, 7)];
        rb  = (rop == 8'h03 || rop == 8'h02) ? 8'($urandom_range(0, 11)) : 8'($urandom);
      end
      exp_q.push_back(ref_alu(int'(ra), int'(rb), int'(rop)));
      send_triplet(ra, rb, rop);
    end
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      wait_frame(v, ok);
      n_cmp++;
      if (!ok || v != e) begin
        n_bad++;
        $display("FAIL b2b_%0d: got %0h (seen %0d) expected %02h", k, v, ok, e);
      end
    end
    #(12 * BIT_NS);
    n_cmp++;
    if (rxq.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_extra: %0d extra frames, expected 0", rxq.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_invalid_op();
    test_ops();
    test_glitch();
    test_framing();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
